// File: rtl/seg_result_decoder.sv
// ---------------------------------------------------------------------------
// seg_result_decoder
//
// Readback monitor for the add/sub/mul result display. Samples the 8-bit
// 7-segment bus, waits until a pattern has been identical for STABLE_CYCLES
// consecutive edges, then decodes it to a signed 3-bit value or an overflow
// marker. Decoded entries go into a small show-ahead FIFO. Settled patterns
// that are not in the decode table are counted and never queued.
//
// Ports
//   clk_2       in   1      system clock, rising edge
//   rst_n       in   1      synchronous reset, active-low
//   seg_in      in   8      7-seg pattern, bit7 = minus/overflow segment
//   rd_en       in   1      pop FIFO head (ignored when valid=0)
//   valid       out  1      FIFO not empty
//   val_out     out  3      signed head value (two's complement), 0 when empty
//   ovf_out     out  1      head entry is the overflow marker, 0 when empty
//   fifo_full   out  1      FIFO holds FIFO_DEPTH entries
//   err_count   out  CNT_W  settled patterns not in the decode table (saturating)
//   drop_count  out  CNT_W  accepted entries lost to a full FIFO (saturating)
//   dbg_state   out  1      sampler FSM state (0 = SETTLE, 1 = LOCKED)
//
// Handshake: the head entry is presented on val_out/ovf_out whenever
// valid=1; it is consumed on a rising edge where rd_en=1 and valid=1.
// rd_en with valid=0 has no effect. There is no backpressure on the
// producer side: an accept into a full FIFO with no pop on that edge is
// dropped and counted.
// ---------------------------------------------------------------------------
module seg_result_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk_2,
    input  logic             rst_n,
    input  logic [7:0]       seg_in,
    input  logic             rd_en,
    output logic             valid,
    output logic [2:0]       val_out,
    output logic             ovf_out,
    output logic             fifo_full,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             dbg_state
);

    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Sampler
    // ------------------------------------------------------------------
    logic [7:0]       r_last_seg;
    logic [RUN_W-1:0] r_run;
    state_t           r_state;

    logic             w_change;
    logic [RUN_W-1:0] w_run_nxt;
    state_t           w_state_nxt;
    logic             w_accept;

    // run==0 only right after reset, so the first sample always starts a run.
    always_comb begin
        w_change  = (r_run == '0) || (seg_in != r_last_seg);
        w_run_nxt = r_run;
        if (w_change) begin
            w_run_nxt = RUN_W'(1);
        end else if (r_run != RUN_MAX) begin
            w_run_nxt = r_run + RUN_W'(1);
        end
    end

    // A change always drops back to SETTLE, so a change counts as SETTLE for
    // the accept test; this is what lets STABLE_CYCLES=1 accept a new pattern
    // on its very first sample even when coming from LOCKED.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        if ((w_change || (r_state == ST_SETTLE)) && (w_run_nxt == RUN_MAX)) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_LOCKED;
        end else if (w_change) begin
            w_state_nxt = ST_SETTLE;
        end
    end

    always_ff @(posedge clk_2) begin
        if (!rst_n) begin
            r_last_seg <= 8'h00;
            r_run      <= '0;
            r_state    <= ST_SETTLE;
        end else begin
            r_last_seg <= seg_in;
            r_run      <= w_run_nxt;
            r_state    <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Decoder (seg_in equals the settled pattern on every accept edge)
    // ------------------------------------------------------------------
    logic       w_code_ok;
    logic       w_code_ovf;
    logic [2:0] w_code_val;

    always_comb begin
        w_code_ok  = 1'b1;
        w_code_ovf = 1'b0;
        w_code_val = 3'b000;
        case (seg_in)
            8'h3F: w_code_val = 3'b000;
            8'h06: w_code_val = 3'b001;
            8'h5B: w_code_val = 3'b010;
            8'h4F: w_code_val = 3'b011;
            8'h86: w_code_val = 3'b111;
            8'hDB: w_code_val = 3'b110;
            8'hCF: w_code_val = 3'b101;
            8'hE6: w_code_val = 3'b100;
            8'h80: w_code_ovf = 1'b1;
            default: w_code_ok = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO; pointers carry one extra wrap bit to tell full
    // from empty.
    // ------------------------------------------------------------------
    logic [3:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_drop_count;

    logic       w_empty;
    logic       w_full;
    logic       w_push_req;
    logic       w_push;
    logic       w_pop;
    logic       w_drop;
    logic       w_err;
    logic [3:0] w_head;

    always_comb begin
        w_empty    = (r_wr_ptr == r_rd_ptr);
        w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_push_req = w_accept && w_code_ok;
        w_pop      = rd_en && !w_empty;
        // A pop on the same edge frees the head slot, so a full FIFO can
        // still take the new entry (it lands in the slot being vacated).
        w_push     = w_push_req && (!w_full || w_pop);
        w_drop     = w_push_req && w_full && !w_pop;
        w_err      = w_accept && !w_code_ok;
        w_head     = r_mem[r_rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk_2) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {w_code_ovf, w_code_val};
        end
    end

    always_ff @(posedge clk_2) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_err_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
            if (w_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign valid      = !w_empty;
    assign val_out    = w_empty ? 3'b000 : w_head[2:0];
    assign ovf_out    = w_empty ? 1'b0   : w_head[3];
    assign fifo_full  = w_full;
    assign err_count  = r_err_count;
    assign drop_count = r_drop_count;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_seg_result_decoder.sv
module tb_seg_result_decoder;

  logic       clk_2;
  logic       rst_n;
  logic [7:0] seg_in;
  logic       rd_en;
  logic       valid;
  logic [2:0] val_out;
  logic       ovf_out;
  logic       fifo_full;
  logic [7:0] err_count;
  logic [7:0] drop_count;
  logic       dbg_state;

  seg_result_decoder #(
    .STABLE_CYCLES(4),
    .FIFO_DEPTH(4),
    .CNT_W(8)
  ) dut (
    .clk_2(clk_2),
    .rst_n(rst_n),
    .seg_in(seg_in),
    .rd_en(rd_en),
    .valid(valid),
    .val_out(val_out),
    .ovf_out(ovf_out),
    .fifo_full(fifo_full),
    .err_count(err_count),
    .drop_count(drop_count),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk_2 = 1'b0;
    forever #5 clk_2 = ~clk_2;
  end

  // scoreboard: {ovf, val}
  logic [3:0] exp_q[$];
  int n_cmp;
  int n_fail;
  int exp_err;
  int exp_drop;

  typedef struct {
    logic [7:0] seg;
    logic       ok;
    logic       ovf;
    logic [2:0] val;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // inputs change just after the falling edge; outputs are read there too
  task automatic hold(input logic [7:0] s, input int n);
    seg_in = s;
    repeat (n) @(negedge clk_2);
  endtask

  task automatic pop_one(input string name);
    logic [3:0] e;
    chk({name, "_valid"}, int'(valid), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'h0;
    chk({name, "_head"}, int'({ovf_out, val_out}), int'(e));
    rd_en = 1'b1;
    @(negedge clk_2);
    rd_en = 1'b0;
  endtask

  task automatic chk_counters(input string name);
    chk({name, "_err"}, int'(err_count), exp_err);
    chk({name, "_drop"}, int'(drop_count), exp_drop);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk_2);
    rst_n = 1'b1;
    exp_q.delete();
    exp_err  = 0;
    exp_drop = 0;
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    exp_err  = 0;
    exp_drop = 0;
    rst_n    = 1'b0;
    rd_en    = 1'b0;
    seg_in   = 8'h00;

    tbl[0]  = '{8'h3F, 1'b1, 1'b0, 3'b000};
    tbl[1]  = '{8'h06, 1'b1, 1'b0, 3'b001};
    tbl[2]  = '{8'h5B, 1'b1, 1'b0, 3'b010};
    tbl[3]  = '{8'h4F, 1'b1, 1'b0, 3'b011};
    tbl[4]  = '{8'h86, 1'b1, 1'b0, 3'b111};
    tbl[5]  = '{8'hDB, 1'b1, 1'b0, 3'b110};
    tbl[6]  = '{8'hCF, 1'b1, 1'b0, 3'b101};
    tbl[7]  = '{8'hE6, 1'b1, 1'b0, 3'b100};
    tbl[8]  = '{8'h80, 1'b1, 1'b1, 3'b000};
    tbl[9]  = '{8'h55, 1'b0, 1'b0, 3'b000};
    tbl[10] = '{8'h00, 1'b0, 1'b0, 3'b000};
    tbl[11] = '{8'hFF, 1'b0, 1'b0, 3'b000};
    tbl[12] = '{8'h3F, 1'b1, 1'b0, 3'b000};

    repeat (2) @(negedge clk_2);
    do_reset();

    // reset state
    chk("rst_valid", int'(valid), 0);
    chk("rst_val", int'(val_out), 0);
    chk("rst_ovf", int'(ovf_out), 0);
    chk("rst_full", int'(fifo_full), 0);
    chk("rst_state", int'(dbg_state), 0);
    chk_counters("rst");

    // 1: 3F held 14 cycles -> exactly one entry after 4th edge
    hold(8'h3F, 3);
    chk("t1_not_yet", int'(valid), 0);
    exp_q.push_back(4'b0000);
    hold(8'h3F, 1);
    chk("t1_valid", int'(valid), 1);
    chk("t1_locked", int'(dbg_state), 1);
    hold(8'h3F, 10);
    pop_one("t1");
    chk("t1_one_only", int'(valid), 0);

    // 2: E6 then overflow marker
    exp_q.push_back(4'b0100);
    hold(8'hE6, 4);
    pop_one("t2_neg4");
    exp_q.push_back(4'b1000);
    hold(8'h80, 4);
    pop_one("t2_ovf");

    // 3: glitch to 5B restarts the run; 5B never accepted
    hold(8'h06, 3);
    hold(8'h5B, 1);
    exp_q.push_back(4'b0001);
    hold(8'h06, 4);
    chk_counters("t3");
    pop_one("t3");
    chk("t3_single", int'(valid), 0);

    // 4: invalid pattern held long -> one error only
    hold(8'h55, 100);
    exp_err++;
    chk_counters("t4");
    chk("t4_no_push", int'(valid), 0);
    exp_q.push_back(4'b0011);
    hold(8'h4F, 4);
    pop_one("t4");

    // 5a: five accepts into depth-4 FIFO with no reads -> one drop
    exp_q.push_back(4'b0000);
    hold(8'h3F, 4);
    exp_q.push_back(4'b0001);
    hold(8'h06, 4);
    exp_q.push_back(4'b0010);
    hold(8'h5B, 4);
    exp_q.push_back(4'b0011);
    hold(8'h4F, 4);
    chk("t5_full4", int'(fifo_full), 1);
    hold(8'h86, 4);
    exp_drop++;
    chk("t5_full", int'(fifo_full), 1);
    chk_counters("t5a");
    for (int i = 0; i < 4; i++) pop_one("t5a_pop");
    chk("t5a_empty", int'(valid), 0);

    // 5b: pop on the 5th accept edge -> no drop, -1 queued last
    exp_q.push_back(4'b0000);
    hold(8'h3F, 4);
    exp_q.push_back(4'b0001);
    hold(8'h06, 4);
    exp_q.push_back(4'b0010);
    hold(8'h5B, 4);
    exp_q.push_back(4'b0011);
    hold(8'h4F, 4);
    hold(8'h86, 3);
    pop_one("t5b_popedge");
    exp_q.push_back(4'b0111);
    chk("t5b_full", int'(fifo_full), 1);
    chk_counters("t5b");
    for (int i = 0; i < 4; i++) pop_one("t5b_pop");
    chk("t5b_empty", int'(valid), 0);

    // 6: reset mid-settle with entries queued
    hold(8'h3F, 4);
    hold(8'h06, 4);
    hold(8'h55, 4);
    chk("t6_two", int'(valid), 1);
    hold(8'h5B, 2);
    seg_in = 8'h5B;
    do_reset();
    chk("t6_valid", int'(valid), 0);
    chk("t6_val", int'(val_out), 0);
    chk("t6_full", int'(fifo_full), 0);
    chk_counters("t6");
    hold(8'h5B, 3);
    chk("t6_not_yet", int'(valid), 0);
    exp_q.push_back(4'b0010);
    hold(8'h5B, 1);
    pop_one("t6");

    // table-driven: every decode entry plus a few error codes
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].ok) exp_q.push_back({tbl[i].ovf, tbl[i].val});
      else exp_err++;
      hold(tbl[i].seg, 4);
      chk_counters("tbl");
      if (tbl[i].ok) pop_one("tbl");
      else chk("tbl_no_push", int'(valid), 0);
    end

    // error counter saturation
    for (int i = 0; i < 260; i++) begin
      hold((i % 2 == 0) ? 8'hAA : 8'h55, 4);
      if (exp_err < 255) exp_err++;
    end
    chk_counters("err_sat");

    // drop counter saturation
    exp_q.push_back(4'b0000);
    hold(8'h3F, 4);
    exp_q.push_back(4'b0001);
    hold(8'h06, 4);
    exp_q.push_back(4'b0010);
    hold(8'h5B, 4);
    exp_q.push_back(4'b0011);
    hold(8'h4F, 4);
    for (int i = 0; i < 260; i++) begin
      hold((i % 2 == 0) ? 8'h86 : 8'hDB, 4);
      if (exp_drop < 255) exp_drop++;
    end
    chk_counters("drop_sat");
    for (int i = 0; i < 4; i++) pop_one("sat_pop");
    chk("sat_empty", int'(valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
